bin_to_bcd_seq: RTL

Sequential, parametrised binary-to-BCD converter: the successor to the 16-bit combinational `b16toBCD` decoder that feeds the seven-segment display path. It converts a WIDTH-bit unsigned value into DIGITS packed BCD digits using an iterative shift-and-add-3 (double-dabble) datapath. A start/busy/done handshake and a registered result replace the purely combinational version, so wide inputs close timing.

---
 rtl/bin_to_bcd_seq.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done handshake.
// Optional leading-zero blanking is compiled in with `define BCD_LEADING_ZERO_BLANK_EN.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      to_display,
  input  logic                  enable,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [SW-1:0]   scratch_q, scratch_d;
  logic [SW-1:0]   result_q, result_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [SW-1:0]    adj;
  logic [SW-1:0]    scratch_sh;
  logic [WIDTH-1:0] bin_sh;
  logic             unused_msb;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};
  logic [DIGITS-1:0] blank_q, blank_d;
  logic [DIGITS-1:0] blank_calc;
  logic              zero_run;
`endif

  // Next-state logic: one add-3/shift step per SHIFT cycle; result and mask latch on the final step.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    result_d  = result_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    adj = '0;
    for (int k = 0; k < DIGITS; k++) begin
      adj[4*k +: 4] = (scratch_q[4*k +: 4] >= 4'd5) ? scratch_q[4*k +: 4] + 4'd3
                                                     : scratch_q[4*k +: 4];
    end
    // The top digit never exceeds 7 after adjustment, so the bit shifted out is always zero.
    {unused_msb, scratch_sh, bin_sh} = {adj, bin_q, 1'b0};

`ifdef BCD_LEADING_ZERO_BLANK_EN
    blank_d    = blank_q;
    blank_calc = '0;
    zero_run   = 1'b1;
    for (int k = DIGITS - 1; k > 0; k--) begin
      zero_run      = zero_run & (scratch_sh[4*k +: 4] == 4'd0);
      blank_calc[k] = zero_run;
    end
`endif

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          bin_d     = to_display;
          scratch_d = '0;
          cnt_d     = CW'(WIDTH);
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      SHIFT: begin
        bin_d     = bin_sh;
        scratch_d = scratch_sh;
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          result_d = scratch_sh;
`ifdef BCD_LEADING_ZERO_BLANK_EN
          blank_d  = blank_calc;
`endif
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bin_q     <= '0;
      scratch_q <= '0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef BCD_LEADING_ZERO_BLANK_EN
      blank_q   <= BLANK_RST;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef BCD_LEADING_ZERO_BLANK_EN
      blank_q   <= blank_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = enable ? result_q : '0;

`ifdef BCD_LEADING_ZERO_BLANK_EN
  assign blank = enable ? blank_q : '1;
`else
  assign blank = '0;
`endif

endmodule
